// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin burst arbiter sharing the uio pin bank, with bus turnaround before each burst
// Ports: clk, rst (sync, active-high), ena; per-requester req/dir/len/wdata; uio_in/uio_out/uio_oe pads;
//        gnt one-hot grant, wr_ack write-beat strobe, rd_data/rd_valid read capture, busy.
module uio_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int LEN_W    = 4,
  parameter int TURN_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       dir,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ*8-1:0]     wdata,
  input  logic [7:0]             uio_in,
  output logic [7:0]             uio_out,
  output logic [7:0]             uio_oe,
  output logic [N_REQ-1:0]       gnt,
  output logic                   wr_ack,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TURN_CYC + 1);
  typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] ptr, win, sel;
  logic [LEN_W-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic wr, found, start, rd_beat;
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        sel = IW'((int'(ptr) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end
  assign start = state == IDLE && ena && found;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? TURN : IDLE) :
                state == TURN ? (tcnt == TW'(1) ? XFER : TURN) :
                (cnt == '0 ? IDLE : XFER);
  end
  assign busy    = state != IDLE;
  assign gnt     = busy ? N_REQ'(1) << win : '0;
  assign wr_ack  = state == XFER && wr;
  assign rd_beat = state == XFER && !wr;
  assign uio_oe  = {8{wr_ack}};
  assign uio_out = wr_ack ? wdata[8*int'(win) +: 8] : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      wr       <= 1'b0;
      cnt      <= '0;
      tcnt     <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= rd_beat;
      if (rd_beat) rd_data <= uio_in;
      if (start) begin
        win  <= sel;
        wr   <= dir[sel];
        cnt  <= len[LEN_W*int'(sel) +: LEN_W];
        tcnt <= TW'(TURN_CYC);
      end
      if (state == TURN) tcnt <= tcnt - TW'(1);
      if (state == XFER) begin
        cnt <= cnt - LEN_W'(1);
        if (cnt == '0) ptr <= win == IW'(N_REQ - 1) ? '0 : win + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: directed and randomized checks of uio_bus_arbiter against a burst-schedule model
module tb_uio_bus_arbiter;
  localparam int N = 4, LW = 4, TC = 1;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0;
  logic [N-1:0] req = '0, dir = '0;
  logic [N*LW-1:0] len = '0;
  logic [N*8-1:0] wdata = '0;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out, uio_oe, rd_data;
  logic [N-1:0] gnt;
  logic wr_ack, rd_valid, busy;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  uio_bus_arbiter #(.N_REQ(N), .LEN_W(LW), .TURN_CYC(TC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .len(len), .wdata(wdata),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .gnt(gnt), .wr_ack(wr_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: every granted burst is expanded into a list of per-cycle expectations.
  typedef struct {bit busy; bit wr; bit rd; int idx;} ent_t;
  ent_t q[$];
  ent_t cur = '{1'b0, 1'b0, 1'b0, 0};
  bit erv = 1'b0, started = 1'b0;
  logic [7:0] erd = 8'h00;
  int mptr = 0;
  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      q.delete();
      cur = '{1'b0, 1'b0, 1'b0, 0};
      erv = 1'b0;
      erd = 8'h00;
      mptr = 0;
    end else begin
      erv = cur.rd;
      if (cur.rd) erd = uio_in;
      if (!cur.busy && ena && req != '0) begin
        int w;
        w = mptr;
        while (!req[w]) w = (w + 1) % N;
        repeat (TC) q.push_back('{1'b1, 1'b0, 1'b0, w});
        for (int b = 0; b <= int'(len[w*LW +: LW]); b++) q.push_back('{1'b1, dir[w], !dir[w], w});
        mptr = (w + 1) % N;
      end
      cur = q.size() > 0 ? q.pop_front() : '{1'b0, 1'b0, 1'b0, 0};
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("gnt", 32'(gnt), cur.busy ? 32'(1) << cur.idx : 32'(0));
      chk("uio_oe", 32'(uio_oe), cur.wr ? 32'hFF : 32'h0);
      chk("uio_out", 32'(uio_out), cur.wr ? 32'(wdata[cur.idx*8 +: 8]) : 32'h0);
      chk("wr_ack", 32'(wr_ack), 32'(cur.wr));
      chk("busy", 32'(busy), 32'(cur.busy));
      chk("rd_valid", 32'(rd_valid), 32'(erv));
      chk("rd_data", 32'(rd_data), 32'(erd));
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    int got[$];
    int rise[$];
    int na, cyc, gi;
    logic [N-1:0] prev;
    step(3);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_oe", 32'(uio_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    rst = 1'b0;
    ena = 1'b1;
    req = 4'b0001; dir = 4'b0001; len = 16'h0002; wdata = 32'h000000A5;
    step();
    chk("t1_turn_gnt", 32'(gnt), 32'h1);
    chk("t1_turn_oe", 32'(uio_oe), 0);
    req = '0;
    for (int b = 0; b < 3; b++) begin
      step();
      chk("t1_beat_oe", 32'(uio_oe), 32'hFF);
      chk("t1_beat_out", 32'(uio_out), 32'hA5);
      chk("t1_beat_ack", 32'(wr_ack), 1);
      chk("t1_beat_gnt", 32'(gnt), 32'h1);
    end
    step();
    chk("t1_end_oe", 32'(uio_oe), 0);
    chk("t1_end_gnt", 32'(gnt), 0);
    req = 4'b0010; dir = '0; len = '0; uio_in = 8'h3C;
    step();
    req = '0;
    step();
    chk("t2_beat_oe", 32'(uio_oe), 0);
    chk("t2_beat_ack", 32'(wr_ack), 0);
    step();
    chk("t2_rd_valid", 32'(rd_valid), 1);
    chk("t2_rd_data", 32'(rd_data), 32'h3C);
    step();
    chk("t2_rd_valid_off", 32'(rd_valid), 0);
    do_reset();
    req = 4'b1111; dir = 4'b1111; len = '0;
    prev = '0;
    cyc = 0;
    while (got.size() < 6 && cyc < 60) begin
      step();
      cyc++;
      if (gnt != '0 && prev == '0) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
        got.push_back(gi);
        rise.push_back(cyc);
      end
      prev = gnt;
    end
    req = '0;
    chk("t3_count", 32'(got.size()), 6);
    if (got.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t3_order", 32'(got[i]), 32'(i % 4));
      for (int i = 1; i < 6; i++) chk("t3_spacing", 32'(rise[i] - rise[i-1]), 32'(2 + TC));
    end
    step(3);
    do_reset();
    req = 4'b0100; dir = 4'b0100; len = 16'h0300; wdata = 32'h005A0000;
    step();
    step();
    na = int'(wr_ack);
    req = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      na += int'(wr_ack);
    end
    chk("t4_beats", 32'(na), 4);
    req = 4'b1100; dir = '0; len = '0;
    step();
    chk("t4_ptr_gnt", 32'(gnt), 32'h8);
    req = '0;
    step(4);
    do_reset();
    req = 4'b0001; dir = 4'b0001; len = 16'h0005; wdata = 32'h000000C3;
    step();
    req = '0;
    step(2);
    chk("t5_beat2_ack", 32'(wr_ack), 1);
    rst = 1'b1;
    step();
    chk("t5_rst_oe", 32'(uio_oe), 0);
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    req = 4'b0011; dir = '0;
    step();
    chk("t5_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    step(6);
    do_reset();
    ena = 1'b0;
    req = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_gnt_off", 32'(gnt), 0);
    end
    ena = 1'b1;
    step();
    chk("t6_gnt_on", 32'(gnt), 32'h8);
    req = '0;
    step(4);
    for (int i = 0; i < 3000; i++) begin
      req = N'($urandom);
      dir = N'($urandom);
      len = (N*LW)'($urandom);
      wdata = $urandom;
      uio_in = 8'($urandom);
      ena = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 1'b0;
    ena = 1'b0;
    req = '0;
    step(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
